// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, one-deep skid buffer
// and redirect kill handling for a single outstanding imem request.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  PC_STEP     = 1,
    parameter logic [7:0]          BUBBLE_CODE = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [4:0]             OPcode,
    output logic [2:0]             ALUop
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FULL
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic                   kill_q, kill_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;
    logic                   id_valid_q, id_valid_d;
    logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;
    logic [PC_WIDTH-1:0]    id_pc_q, id_pc_d;

    logic                   accept;
    logic [PC_WIDTH-1:0]    addr_next;

    assign accept    = !id_valid_q || !stall;
    assign addr_next = addr_q + PC_WIDTH'(PC_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= '0;
            kill_q       <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            kill_q       <= kill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        kill_d       = kill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;

        // Decode consumed the word; a fill below may replace it.
        if (accept) begin
            id_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                addr_d  = pc_q;
                if (redirect_valid) begin
                    pc_d   = redirect_pc;
                    addr_d = redirect_pc;
                end
            end

            S_FETCH: begin
                if (imem_ack) begin
                    if (kill_q || redirect_valid) begin
                        kill_d = 1'b0;
                        if (redirect_valid) begin
                            pc_d   = redirect_pc;
                            addr_d = redirect_pc;
                        end else begin
                            addr_d = pc_q;
                        end
                    end else if (accept) begin
                        id_valid_d = 1'b1;
                        id_instr_d = imem_rdata;
                        id_pc_d    = addr_q;
                        pc_d       = addr_next;
                        addr_d     = addr_next;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = addr_q;
                        pc_d         = addr_next;
                        addr_d       = addr_next;
                        state_d      = S_FULL;
                    end
                end else if (redirect_valid) begin
                    // Request must stay stable until acked; drop it then.
                    kill_d = 1'b1;
                    pc_d   = redirect_pc;
                end
            end

            S_FULL: begin
                if (redirect_valid) begin
                    state_d = S_FETCH;
                    pc_d    = redirect_pc;
                    addr_d  = redirect_pc;
                end else if (accept) begin
                    id_valid_d = 1'b1;
                    id_instr_d = skid_instr_q;
                    id_pc_d    = skid_pc_q;
                    state_d    = S_FETCH;
                    addr_d     = pc_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect_valid) begin
            id_valid_d = 1'b0;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = addr_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign OPcode    = id_valid_q ? id_instr_q[31:27] : BUBBLE_CODE[7:3];
    assign ALUop     = id_valid_q ? id_instr_q[26:24] : BUBBLE_CODE[2:0];

endmodule
